// File: rtl/fifo_rr_write_arbiter.sv
`default_nettype none
// =============================================================================
//  Module   : fifo_rr_write_arbiter
//  Purpose  : Round-robin, burst-bounded sharing of one FIFO write port among
//             NUM_REQ valid/ready producers, back-pressured by fifo_full.
//  Revision : 1.0  initial release
// =============================================================================
module fifo_rr_write_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 128,
    parameter int MAX_BURST = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       fifo_full,
    output logic                       fifo_write_en,
    output logic [WIDTH-1:0]           fifo_data_in,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy
);

    localparam int c_gw = $clog2(NUM_REQ);
    localparam int c_cw = $clog2(MAX_BURST + 1);
    localparam logic [c_gw-1:0] c_last_id   = c_gw'(NUM_REQ - 1);
    localparam logic [c_cw-1:0] c_last_beat = c_cw'(MAX_BURST - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t            r_state;
    logic [c_gw-1:0]   r_rr_ptr;
    logic [c_gw-1:0]   r_grant_id;
    logic [c_cw-1:0]   r_burst_cnt;

    logic [WIDTH-1:0]  w_data [NUM_REQ];
    logic              w_found;
    logic [c_gw-1:0]   w_pick;
    int                w_idx;
    logic              w_xfer;
    logic              w_release;
    logic [c_gw-1:0]   w_next_ptr;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_data[gi] = req_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Scan from the highest offset down so the closest valid index after
    // rr_ptr is the last one written.
    always_comb begin
        w_found = |req_valid;
        w_pick  = '0;
        w_idx   = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = int'(r_rr_ptr) + k;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            if (req_valid[w_idx]) begin
                w_pick = c_gw'(w_idx);
            end
        end
    end

    assign w_xfer     = (r_state == S_GRANT) && req_valid[r_grant_id] && !fifo_full;
    assign w_release  = !req_valid[r_grant_id] || (w_xfer && (r_burst_cnt == c_last_beat));
    assign w_next_ptr = (r_grant_id == c_last_id) ? '0 : r_grant_id + c_gw'(1);

    always_comb begin
        req_ready             = '0;
        req_ready[r_grant_id] = w_xfer;
    end

    assign fifo_write_en = w_xfer;
    assign fifo_data_in  = w_xfer ? w_data[r_grant_id] : '0;
    assign grant_id      = r_grant_id;
    assign busy          = (r_state == S_GRANT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_grant_id  <= '0;
            r_burst_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant_id  <= w_pick;
                        r_burst_cnt <= '0;
                        r_state     <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (w_release) begin
                        r_rr_ptr    <= w_next_ptr;
                        r_burst_cnt <= '0;
                        r_state     <= S_IDLE;
                    end else if (w_xfer) begin
                        r_burst_cnt <= r_burst_cnt + c_cw'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_rr_write_arbiter.sv
`default_nettype none
// =============================================================================
//  Module   : tb_fifo_rr_write_arbiter
//  Purpose  : Directed self-checking bench for fifo_rr_write_arbiter.
//  Revision : 1.0  initial release
// =============================================================================
module tb_fifo_rr_write_arbiter;

    localparam int N  = 4;
    localparam int W  = 128;
    localparam int MB = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0]   req_ready;
    logic           fifo_full = 1'b0;
    logic           fifo_write_en;
    logic [W-1:0]   fifo_data_in;
    logic [1:0]     grant_id;
    logic           busy;

    fifo_rr_write_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .fifo_full(fifo_full), .fifo_write_en(fifo_write_en),
        .fifo_data_in(fifo_data_in), .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           cyc;
        int           gid;
        logic [W-1:0] d;
    } ent_t;

    int           n_chk = 0;
    int           n_err = 0;
    int           cyc = 0;
    bit           cmp_en = 1'b0;
    logic [W-1:0] pq [N][$];
    ent_t         log_q [$];

    // model: owner of the port (-1 = arbitrating), beats left in the grant
    int m_owner = -1;
    int m_gid   = 0;
    int m_ptr   = 0;
    int m_left  = 0;

    function automatic logic [W-1:0] mk(input int p, input int b);
        return {32'hC0DE0000 | 32'(p), 32'(b), 64'h0123_4567_89AB_CDEF};
    endfunction

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_ent(input string nm, input int i, input int ecyc, input int egid,
                           input logic [W-1:0] ed);
        if (i >= log_q.size()) begin
            n_chk++;
            n_err++;
            $display("FAIL %s[%0d]: got no write, expected write of %h", nm, i, ed);
        end else begin
            chk({nm, "_cyc"}, W'(log_q[i].cyc), W'(ecyc));
            chk({nm, "_gid"}, W'(log_q[i].gid), W'(egid));
            chk({nm, "_data"}, log_q[i].d, ed);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(posedge clk or negedge rst) begin
        bit x;
        int idx;
        if (!rst) begin
            m_owner = -1; m_gid = 0; m_ptr = 0; m_left = 0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (m_owner < 0 && req_valid[idx]) begin
                    m_owner = idx; m_gid = idx; m_left = MB;
                end
            end
        end else begin
            x = req_valid[m_gid] && !fifo_full;
            if (x) m_left--;
            if (!req_valid[m_gid] || m_left == 0) begin
                m_owner = -1;
                m_ptr   = (m_gid + 1) % N;
            end
        end
    end

    always @(negedge clk) begin
        bit           x;
        logic [N-1:0] er;
        logic [W-1:0] ed;
        if (cmp_en) begin
            x  = (m_owner >= 0) && req_valid[m_gid] && !fifo_full;
            er = '0;
            if (x) er[m_gid] = 1'b1;
            ed = x ? req_data[m_gid*W +: W] : '0;
            chk("ready", W'(req_ready), W'(er));
            chk("write_en", W'(fifo_write_en), W'(x));
            chk("data", fifo_data_in, ed);
            chk("grant_id", W'(grant_id), W'(m_gid));
            chk("busy", W'(busy), W'(m_owner >= 0));
            if (fifo_write_en) log_q.push_back('{cyc, int'(grant_id), fifo_data_in});
        end
    end

    // Producers: hold the queue head until it is accepted at a clock edge.
    initial begin
        logic [N-1:0] acc;
        forever begin
            @(negedge clk);
            acc = req_ready;
            @(posedge clk);
            if (!rst) acc = '0;
            #2;
            for (int i = 0; i < N; i++) begin
                if (acc[i] && pq[i].size() > 0) void'(pq[i].pop_front());
                req_valid[i]        = (pq[i].size() > 0);
                req_data[i*W +: W]  = (pq[i].size() > 0) ? pq[i][0] : '0;
            end
        end
    end

    task automatic wait_idle();
        int t = 0;
        int pend = 1;
        while ((pend > 0 || busy) && t < 300) begin
            @(negedge clk);
            t++;
            pend = 0;
            for (int i = 0; i < N; i++) pend += pq[i].size();
        end
        if (t >= 300) begin
            n_chk++;
            n_err++;
            $display("FAIL wait_idle: still busy after %0d cycles, required idle", t);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        log_q.delete();
    endtask

    initial begin
        int n0;
        #2 rst = 1'b0;
        cmp_en = 1'b1;
        #1;
        chk("rst_ready", W'(req_ready), '0);
        chk("rst_we", W'(fifo_write_en), '0);
        chk("rst_data", fifo_data_in, '0);
        chk("rst_gid", W'(grant_id), '0);
        chk("rst_busy", W'(busy), '0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // single producer, three beats, then valid drop releases
        @(posedge clk); #1;
        n0 = cyc;
        for (int b = 0; b < 3; b++) pq[0].push_back(mk(0, b));
        wait_idle();
        chk("t1_count", W'(log_q.size()), W'(3));
        for (int b = 0; b < 3; b++) chk_ent("t1", b, n0 + 1 + b, 0, mk(0, b));
        chk("t1_rr_ptr", W'(dut.r_rr_ptr), W'(1));
        chk("t1_model_ptr", W'(m_ptr), W'(1));

        // all four producers busy: 0,1,2,3,0 with one idle cycle between grants
        do_reset();
        n0 = cyc;
        for (int b = 0; b < 8; b++) pq[0].push_back(mk(0, b));
        for (int p = 1; p < N; p++)
            for (int b = 0; b < 4; b++) pq[p].push_back(mk(p, b));
        wait_idle();
        chk("t2_count", W'(log_q.size()), W'(20));
        for (int g = 0; g < 5; g++)
            for (int k = 0; k < 4; k++)
                chk_ent("t2", g*4 + k, n0 + 1 + 5*g + k, g % 4, mk(g % 4, (g == 4) ? 4 + k : k));

        // full for three cycles after beat 2
        log_q.delete();
        n0 = cyc;
        for (int b = 0; b < 4; b++) pq[1].push_back(mk(1, b));
        repeat (3) @(posedge clk);
        #1 fifo_full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t3_we", W'(fifo_write_en), '0);
            chk("t3_ready", W'(req_ready), '0);
            chk("t3_busy", W'(busy), W'(1));
            chk("t3_gid", W'(grant_id), W'(1));
        end
        @(posedge clk);
        #1 fifo_full = 1'b0;
        wait_idle();
        chk_ent("t3", 0, n0 + 1, 1, mk(1, 0));
        chk_ent("t3", 1, n0 + 2, 1, mk(1, 1));
        chk_ent("t3", 2, n0 + 6, 1, mk(1, 2));
        chk_ent("t3", 3, n0 + 7, 1, mk(1, 3));

        // req2 drops after two beats, req3 next
        log_q.delete();
        n0 = cyc;
        for (int b = 0; b < 2; b++) begin
            pq[2].push_back(mk(2, b));
            pq[3].push_back(mk(3, b));
        end
        wait_idle();
        chk_ent("t4", 0, n0 + 1, 2, mk(2, 0));
        chk_ent("t4", 1, n0 + 2, 2, mk(2, 1));
        chk_ent("t4", 2, n0 + 5, 3, mk(3, 0));
        chk_ent("t4", 3, n0 + 6, 3, mk(3, 1));

        // wrap-around priority: rr_ptr=0 after grant 3
        log_q.delete();
        chk("t5_rr_ptr", W'(dut.r_rr_ptr), '0);
        n0 = cyc;
        pq[0].push_back(mk(0, 7));
        pq[3].push_back(mk(3, 7));
        wait_idle();
        chk_ent("t5", 0, n0 + 1, 0, mk(0, 7));
        chk_ent("t5", 1, n0 + 4, 3, mk(3, 7));

        // reset mid-burst on producer 1
        n0 = cyc;
        for (int b = 0; b < 4; b++) pq[1].push_back(mk(1, b));
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("t6_ready", W'(req_ready), '0);
        chk("t6_we", W'(fifo_write_en), '0);
        chk("t6_data", fifo_data_in, '0);
        chk("t6_gid", W'(grant_id), '0);
        chk("t6_busy", W'(busy), '0);
        pq[0].push_back(mk(0, 9));
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        log_q.delete();
        n0 = cyc;
        wait_idle();
        chk_ent("t6", 0, n0 + 1, 0, mk(0, 9));
        chk_ent("t6", 1, n0 + 4, 1, mk(1, 2));
        chk_ent("t6", 2, n0 + 5, 1, mk(1, 3));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
